hazard5_imem_responder: RTL and testbench
=========================================

Name: hazard5_imem_responder

Overview:
- Responder (slave) end of the Hazard5 instruction-fetch interface. It accepts pipelined fetch address phases from the core frontend and returns one data beat per accepted address, in order.
- Backed by a single-ported synchronous instruction SRAM with 1-cycle read latency.
- Supports a fixed number of wait states and dynamic stalls from the SRAM-port arbiter, which is shared with the data-side bus.
- Sits between the frontend and the tightly-coupled instruction memory.

Parameters:
- W_ADDR, 32, fetch address width (only 32 supported).
- W_DATA, 32, data width (only 32 supported).
- SRAM_DEPTH, 4096, SRAM depth in 32-bit words; power of 2.
- WAIT_STATES, 0, extra data-phase cycles per access (0..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_size  in  1  1 = 32-bit access, 0 = 16-bit access
- mem_addr  in  W_ADDR  byte address of the address phase
- mem_addr_vld  in  1  address phase valid
- mem_addr_rdy  out  1  address phase accepted this cycle, if vld
- mem_data  out  W_DATA  read data
- mem_data_vld  out  1  data phase completes this cycle
- sram_gnt  in  1  arbiter grants the SRAM port this cycle (registered in arbiter)
- sram_stall  in  1  arbiter extends the current data phase by one cycle
- sram_ce  out  1  SRAM read enable
- sram_addr  out  $clog2(SRAM_DEPTH)  SRAM word address
- sram_rdata  in  W_DATA  SRAM read data, valid the cycle after sram_ce

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. All state clears: dph_vld=0, wait_ctr=0, hold register=0.
  - mem_data_vld=0, mem_data=0.
  - mem_addr_rdy=sram_gnt (combinational, idle).
  - sram_ce=0 unless mem_addr_vld.
- Reset mid-operation aborts any data phase. No data_vld is ever produced for a pre-reset address.
- Acceptance: accept = mem_addr_vld && mem_addr_rdy.
  - mem_addr_rdy = sram_gnt && (!dph_vld || dph_done).
  - dph_done = dph_vld && wait_ctr==0 && !sram_stall.
  - mem_addr_rdy must not depend combinationally on mem_addr_vld, mem_addr or mem_size.
- SRAM read: issued in the accept cycle.
  - sram_ce = accept.
  - sram_addr = mem_addr[2 +: $clog2(SRAM_DEPTH)]. Upper address bits are ignored, so addresses wrap modulo SRAM size.
- Data phase: starts the cycle after accept.
  - dph_vld<=1, wait_ctr<=WAIT_STATES, dph_hw<=!mem_size, dph_a1<=mem_addr[1].
  - wait_ctr decrements each data-phase cycle with !sram_stall, saturating at 0.
  - First data-phase cycle: hold register captures sram_rdata.
  - mem_data source: sram_rdata if dph_done in the first data-phase cycle, else the hold register.
- Latency and throughput:
  - With WAIT_STATES=0 and no stall, data_vld arrives exactly 1 cycle after accept. Back-to-back accepts give 1 beat/cycle.
  - In general, latency = 1+WAIT_STATES+stall cycles.
- Halfword access (mem_size=0): selected halfword = addr[1] ? word[31:16] : word[15:0]. mem_data = {hw,hw}, replicated so the consumer may take either half.
- Word access with addr[1]=1 is illegal. The responder ignores addr[1] and returns the full aligned word.
- mem_data_vld = dph_done. It is registered-path only, with no combinational path from mem_addr_vld.
- Simultaneous events:
  - dph_done and accept in the same cycle: the new data phase begins next cycle, with no bubble.
  - dph_done with no accept: dph_vld<=0.
- sram_gnt low: mem_addr_rdy=0, so no new accept. A data phase already in progress completes normally, since its read was already issued.
- At most one outstanding access. The core never sees more than one data phase pending.
- mem_addr, mem_size and mem_addr_vld must be stable from assertion until the cycle after rdy. The bench asserts this; the RTL does not check it.

Decomposition:
- Shared package hazard5_bus_defs: size encodings (SIZE_HALF=0, SIZE_WORD=1) and the W_ADDR/W_DATA defaults.
- One natural sub-module: hazard5_imem_dph_ctrl, holding the data-phase valid, wait counter and stall logic, and producing dph_done and mem_addr_rdy.
- Halfword select and replication stay inline.

Test Plan:
- Back-to-back word fetches: WAIT_STATES=0, sram_gnt=1, addresses 0x0,0x4,0x8 on consecutive cycles, SRAM preloaded with word[i]=0x1000_0000+i -> mem_addr_rdy=1 every cycle; mem_data_vld on cycles 1,2,3 with 0x10000000, 0x10000001, 0x10000002.
- Halfword fetch: size=0, addr=0x6, word[1]=0xABCD1234 -> one cycle later mem_data=0xABCDABCD, data_vld=1; addr=0x4 -> 0x12341234.
- Wait states: WAIT_STATES=2, fetch at 0x10 -> data_vld exactly 3 cycles after accept; mem_addr_rdy low for the 2 intermediate cycles and high in the done cycle; data equals word[4].
- Arbiter interaction: sram_stall high for 2 cycles mid data phase -> data_vld delayed by 2 and data unchanged (hold register). sram_gnt low while vld -> no sram_ce and no accept until gnt returns.
- Wrap: SRAM_DEPTH=4096, fetch 0x0000_4008 -> sram_addr=2, returns word[2].
- Reset mid-phase: WAIT_STATES=3, assert rst_n low 1 cycle after accept -> mem_data_vld never asserts for that access; after release, mem_addr_rdy=1 and a fresh fetch returns correct data with latency 4.

Source files
------------

// File: rtl/hazard5_bus_defs.sv
// rtl/hazard5_bus_defs.sv - shared Hazard5 bus definitions
//
// Purpose: transfer-size encodings and default bus widths used by the
// instruction-fetch responder and its data-phase controller.
// Ports: none (package).

package hazard5_bus_defs;

  localparam int W_ADDR_DEFAULT = 32;
  localparam int W_DATA_DEFAULT = 32;

  // Encoding of the mem_size signal on the fetch interface.
  typedef enum logic {
    SIZE_HALF = 1'b0,
    SIZE_WORD = 1'b1
  } mem_size_t;

  // Wait-state counter width; WAIT_STATES is limited to 0..3.
  localparam int W_WAIT_CTR = 2;

endpackage

// File: rtl/hazard5_imem_dph_ctrl.sv
// rtl/hazard5_imem_dph_ctrl.sv - data-phase tracking for the instruction fetch responder
//
// Purpose: tracks the single outstanding data phase, counts wait states,
// applies arbiter stalls, and decides when a new address phase may be accepted.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   sram_gnt      arbiter grants the SRAM port this cycle
//   sram_stall    arbiter extends the current data phase by one cycle
//   accept        address phase accepted this cycle (vld && rdy, from top)
//   dph_first     first cycle of the current data phase (SRAM data on the bus)
//   dph_done      data phase completes this cycle
//   mem_addr_rdy  responder can accept an address phase this cycle

module hazard5_imem_dph_ctrl
  import hazard5_bus_defs::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sram_gnt,
  input  logic sram_stall,
  input  logic accept,
  output logic dph_first,
  output logic dph_done,
  output logic mem_addr_rdy
);

  logic                  dph_vld;
  logic [W_WAIT_CTR-1:0] wait_ctr;

  assign dph_done = dph_vld && (wait_ctr == '0) && !sram_stall;

  // Depends only on registered state and arbiter inputs, never on the
  // requester's address-phase signals, so no loop forms through accept.
  assign mem_addr_rdy = sram_gnt && (!dph_vld || dph_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_vld   <= 1'b0;
      dph_first <= 1'b0;
      wait_ctr  <= '0;
    end else begin
      dph_first <= accept;
      if (accept) begin
        // Accept in the done cycle chains straight into the next phase.
        dph_vld  <= 1'b1;
        wait_ctr <= W_WAIT_CTR'(WAIT_STATES);
      end else begin
        if (dph_done) begin
          dph_vld <= 1'b0;
        end
        if (dph_vld && !sram_stall && (wait_ctr != '0)) begin
          wait_ctr <= wait_ctr - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard5_imem_responder.sv
// rtl/hazard5_imem_responder.sv - Hazard5 instruction-fetch responder onto a synchronous SRAM
//
// Purpose: accepts pipelined fetch address phases, issues one SRAM read per
// accept and returns one in-order data beat per accepted address, with fixed
// wait states and arbiter stalls. Halfword fetches are replicated to both halves.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   mem_size       1 = 32-bit access, 0 = 16-bit access
//   mem_addr       byte address of the address phase
//   mem_addr_vld   address phase valid
//   mem_addr_rdy   address phase accepted this cycle, if vld
//   mem_data       read data
//   mem_data_vld   data phase completes this cycle
//   sram_gnt       arbiter grants the SRAM port this cycle
//   sram_stall     arbiter extends the current data phase by one cycle
//   sram_ce        SRAM read enable
//   sram_addr      SRAM word address
//   sram_rdata     SRAM read data, valid the cycle after sram_ce

module hazard5_imem_responder
  import hazard5_bus_defs::*;
#(
  parameter int W_ADDR      = W_ADDR_DEFAULT,
  parameter int W_DATA      = W_DATA_DEFAULT,
  parameter int SRAM_DEPTH  = 4096,
  parameter int WAIT_STATES = 0,
  localparam int W_SRAM_ADDR = $clog2(SRAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_size,
  input  logic [W_ADDR-1:0]      mem_addr,
  input  logic                   mem_addr_vld,
  output logic                   mem_addr_rdy,
  output logic [W_DATA-1:0]      mem_data,
  output logic                   mem_data_vld,
  input  logic                   sram_gnt,
  input  logic                   sram_stall,
  output logic                   sram_ce,
  output logic [W_SRAM_ADDR-1:0] sram_addr,
  input  logic [W_DATA-1:0]      sram_rdata
);

  localparam int W_HALF = W_DATA / 2;

  logic              accept;
  logic              dph_first;
  logic              dph_done;
  logic              dph_hw;
  logic              dph_a1;
  logic [W_DATA-1:0] hold;
  logic [W_DATA-1:0] word;
  logic [W_HALF-1:0] half;

  assign accept = mem_addr_vld && mem_addr_rdy;

  hazard5_imem_dph_ctrl #(
    .WAIT_STATES (WAIT_STATES)
  ) u_dph_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .sram_gnt     (sram_gnt),
    .sram_stall   (sram_stall),
    .accept       (accept),
    .dph_first    (dph_first),
    .dph_done     (dph_done),
    .mem_addr_rdy (mem_addr_rdy)
  );

  // The read is launched in the accept cycle; upper address bits are dropped
  // so fetches wrap modulo the SRAM size.
  assign sram_ce   = accept;
  assign sram_addr = mem_addr[2 +: W_SRAM_ADDR];

  // Address bits above the SRAM and byte-lane bit 0 carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^(mem_addr >> (W_SRAM_ADDR + 2)) ^ mem_addr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dph_hw <= 1'b0;
      dph_a1 <= 1'b0;
      hold   <= '0;
    end else begin
      if (accept) begin
        dph_hw <= (mem_size_t'(mem_size) == SIZE_HALF);
        dph_a1 <= mem_addr[1];
      end
      // The SRAM may be handed to the data side after the first cycle, so the
      // read data is captured once and replayed from here on stalls/waits.
      if (dph_first) begin
        hold <= sram_rdata;
      end
    end
  end

  assign word = (dph_first && dph_done) ? sram_rdata : hold;

  // Word fetches ignore addr[1] and always return the aligned word.
  assign half = dph_a1 ? word[W_DATA-1:W_HALF] : word[W_HALF-1:0];

  assign mem_data     = dph_hw ? {half, half} : word;
  assign mem_data_vld = dph_done;

endmodule

// File: tb/tb_hazard5_imem_responder.sv
// tb/tb_hazard5_imem_responder.sv - self-checking bench for hazard5_imem_responder

module tb_hazard5_imem_responder;

  localparam int NI = 3;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  logic        rst_n        [NI];
  logic        mem_size     [NI];
  logic [31:0] mem_addr     [NI];
  logic        mem_addr_vld [NI];
  logic        mem_addr_rdy [NI];
  logic [31:0] mem_data     [NI];
  logic        mem_data_vld [NI];
  logic        sram_gnt     [NI];
  logic        sram_stall   [NI];
  logic        sram_ce      [NI];
  logic [11:0] sram_addr    [NI];
  logic [31:0] sram_rdata   [NI];

  logic [31:0] mem [4096];
  exp_t        sb  [NI][$];
  int          ws  [NI] = '{0, 2, 3};

  hazard5_imem_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n[0]), .mem_size(mem_size[0]), .mem_addr(mem_addr[0]),
    .mem_addr_vld(mem_addr_vld[0]), .mem_addr_rdy(mem_addr_rdy[0]),
    .mem_data(mem_data[0]), .mem_data_vld(mem_data_vld[0]),
    .sram_gnt(sram_gnt[0]), .sram_stall(sram_stall[0]), .sram_ce(sram_ce[0]),
    .sram_addr(sram_addr[0]), .sram_rdata(sram_rdata[0])
  );

  hazard5_imem_responder #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n[1]), .mem_size(mem_size[1]), .mem_addr(mem_addr[1]),
    .mem_addr_vld(mem_addr_vld[1]), .mem_addr_rdy(mem_addr_rdy[1]),
    .mem_data(mem_data[1]), .mem_data_vld(mem_data_vld[1]),
    .sram_gnt(sram_gnt[1]), .sram_stall(sram_stall[1]), .sram_ce(sram_ce[1]),
    .sram_addr(sram_addr[1]), .sram_rdata(sram_rdata[1])
  );

  hazard5_imem_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n[2]), .mem_size(mem_size[2]), .mem_addr(mem_addr[2]),
    .mem_addr_vld(mem_addr_vld[2]), .mem_addr_rdy(mem_addr_rdy[2]),
    .mem_data(mem_data[2]), .mem_data_vld(mem_data_vld[2]),
    .sram_gnt(sram_gnt[2]), .sram_stall(sram_stall[2]), .sram_ce(sram_ce[2]),
    .sram_addr(sram_addr[2]), .sram_rdata(sram_rdata[2])
  );

  // SRAM model: 1-cycle read latency; the output bus carries junk when no
  // read was issued, so a design that skips the hold register shows it.
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      sram_rdata[k] <= sram_ce[k] ? mem[sram_addr[k]] : (32'hDEAD_BEEF ^ 32'(cyc));
    end
  end

  // Requester-side protocol: an unaccepted address phase must stay put.
  logic        pend      [NI];
  logic [31:0] pend_addr [NI];
  logic        pend_size [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      pend[k]      <= rst_n[k] && mem_addr_vld[k] && !mem_addr_rdy[k];
      pend_addr[k] <= mem_addr[k];
      pend_size[k] <= mem_size[k];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (pend[k] === 1'b1 && rst_n[k] === 1'b1) begin
        tests++;
        if (mem_addr_vld[k] !== 1'b1 || mem_addr[k] !== pend_addr[k] || mem_size[k] !== pend_size[k]) begin
          failed++;
          $display("FAIL stable_inputs dut%0d got vld=%b addr=%h exp vld=1 addr=%h", k, mem_addr_vld[k], mem_addr[k], pend_addr[k]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout at cycle %0d exp finish", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [31:0] a, input logic s);
    logic [31:0] w;
    logic [15:0] h;
    w = mem[a[13:2]];
    h = a[1] ? w[31:16] : w[15:0];
    return s ? w : {h, h};
  endfunction

  task automatic sb_push(input int i, input logic [31:0] a, input logic s, input int extra);
    exp_t e;
    e.data = model(a, s);
    e.due  = cyc + 1 + ws[i] + extra;
    sb[i].push_back(e);
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] a, input logic s,
                       input logic g, input logic st);
    mem_addr_vld[i] = v;
    mem_addr[i]     = a;
    mem_size[i]     = s;
    sram_gnt[i]     = g;
    sram_stall[i]   = st;
  endtask

  task automatic test_reset();
    logic g;
    for (int k = 0; k < NI; k++) begin
      for (int gi = 0; gi < 2; gi++) begin
        g = (gi == 1);
        drive(k, 1'b0, 32'h0, 1'b1, g, 1'b0);
        #1;
        tests++;
        if (mem_addr_rdy[k] !== g || mem_data_vld[k] !== 1'b0 || mem_data[k] !== 32'h0 || sram_ce[k] !== 1'b0) begin
          failed++;
          $display("FAIL reset_state dut%0d got rdy=%b dv=%b data=%h ce=%b exp rdy=%b dv=0 data=0 ce=0",
                   k, mem_addr_rdy[k], mem_data_vld[k], mem_data[k], sram_ce[k], g);
        end
      end
      sram_gnt[k] = 1'b1;
    end
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [4:0] tv = 5'b00111, tr = 5'b11111, tdv = 5'b01110;
    for (int c = 0; c < 5; c++) begin
      drive(0, tv[c], 32'(c * 4), 1'b1, 1'b1, 1'b0);
      #1;
      tests++;
      if (mem_addr_rdy[0] !== tr[c] || sram_ce[0] !== (tv[c] & tr[c])) begin
        failed++;
        $display("FAIL b2b_handshake c%0d got rdy=%b ce=%b exp rdy=%b ce=%b", c, mem_addr_rdy[0], sram_ce[0], tr[c], tv[c] & tr[c]);
      end
      tests++;
      if (mem_data_vld[0] !== tdv[c]) begin
        failed++;
        $display("FAIL b2b_data_vld c%0d got %b exp %b", c, mem_data_vld[0], tdv[c]);
      end
      if (tv[c] && tr[c]) sb_push(0, 32'(c * 4), 1'b1, 0);
      if (mem_data_vld[0] === 1'b1) begin
        tests++;
        if (sb[0].size() == 0) begin
          failed++;
          $display("FAIL b2b_beat c%0d got unexpected data %h exp no beat", c, mem_data[0]);
        end else begin
          e = sb[0].pop_front();
          if (mem_data[0] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL b2b_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[0], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[0].size() != 0) begin
      failed++;
      $display("FAIL b2b_drain got %0d beats outstanding exp 0", sb[0].size());
      sb[0].delete();
    end
  endtask

  task automatic test_halfword();
    exp_t e;
    logic [2:0] tv = 3'b011, tr = 3'b111, tdv = 3'b110;
    logic [31:0] a;
    mem[1] = 32'hABCD_1234;
    for (int c = 0; c < 3; c++) begin
      a = (c == 0) ? 32'h6 : 32'h4;
      drive(0, tv[c], a, 1'b0, 1'b1, 1'b0);
      #1;
      tests++;
      if (mem_addr_rdy[0] !== tr[c] || mem_data_vld[0] !== tdv[c]) begin
        failed++;
        $display("FAIL hw_handshake c%0d got rdy=%b dv=%b exp rdy=%b dv=%b", c, mem_addr_rdy[0], mem_data_vld[0], tr[c], tdv[c]);
      end
      if (tv[c] && tr[c]) sb_push(0, a, 1'b0, 0);
      if (mem_data_vld[0] === 1'b1) begin
        tests++;
        if (sb[0].size() == 0) begin
          failed++;
          $display("FAIL hw_beat c%0d got unexpected data %h exp no beat", c, mem_data[0]);
        end else begin
          e = sb[0].pop_front();
          if (mem_data[0] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL hw_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[0], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[0].size() != 0) begin
      failed++;
      $display("FAIL hw_drain got %0d beats outstanding exp 0", sb[0].size());
      sb[0].delete();
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [2:0] tv = 3'b011, tdv = 3'b110;
    logic [31:0] a;
    for (int c = 0; c < 3; c++) begin
      a = (c == 0) ? 32'h0000_4008 : 32'h0000_400A;
      drive(0, tv[c], a, 1'b1, 1'b1, 1'b0);
      #1;
      if (tv[c]) begin
        tests++;
        if (sram_ce[0] !== 1'b1 || sram_addr[0] !== 12'd2) begin
          failed++;
          $display("FAIL wrap_sram_addr c%0d got ce=%b addr=%0d exp ce=1 addr=2", c, sram_ce[0], sram_addr[0]);
        end
        sb_push(0, a, 1'b1, 0);
      end
      tests++;
      if (mem_data_vld[0] !== tdv[c]) begin
        failed++;
        $display("FAIL wrap_data_vld c%0d got %b exp %b", c, mem_data_vld[0], tdv[c]);
      end
      if (mem_data_vld[0] === 1'b1) begin
        tests++;
        if (sb[0].size() == 0) begin
          failed++;
          $display("FAIL wrap_beat c%0d got unexpected data %h exp no beat", c, mem_data[0]);
        end else begin
          e = sb[0].pop_front();
          if (mem_data[0] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL wrap_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[0], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[0].size() != 0) begin
      failed++;
      $display("FAIL wrap_drain got %0d beats outstanding exp 0", sb[0].size());
      sb[0].delete();
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    logic [7:0] tv = 8'b0000_1111, tr = 8'b1100_1001, tdv = 8'b0100_1000;
    logic [31:0] a;
    for (int c = 0; c < 8; c++) begin
      a = (c == 0) ? 32'h10 : 32'h14;
      drive(1, tv[c], a, 1'b1, 1'b1, 1'b0);
      #1;
      tests++;
      if (mem_addr_rdy[1] !== tr[c] || sram_ce[1] !== (tv[c] & tr[c])) begin
        failed++;
        $display("FAIL ws_handshake c%0d got rdy=%b ce=%b exp rdy=%b ce=%b", c, mem_addr_rdy[1], sram_ce[1], tr[c], tv[c] & tr[c]);
      end
      tests++;
      if (mem_data_vld[1] !== tdv[c]) begin
        failed++;
        $display("FAIL ws_data_vld c%0d got %b exp %b", c, mem_data_vld[1], tdv[c]);
      end
      if (tv[c] && tr[c]) sb_push(1, a, 1'b1, 0);
      if (mem_data_vld[1] === 1'b1) begin
        tests++;
        if (sb[1].size() == 0) begin
          failed++;
          $display("FAIL ws_beat c%0d got unexpected data %h exp no beat", c, mem_data[1]);
        end else begin
          e = sb[1].pop_front();
          if (mem_data[1] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL ws_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[1], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[1].size() != 0) begin
      failed++;
      $display("FAIL ws_drain got %0d beats outstanding exp 0", sb[1].size());
      sb[1].delete();
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [4:0] tv = 5'b00001, tr = 5'b11001, tdv = 5'b01000, tst = 5'b00110;
    for (int c = 0; c < 5; c++) begin
      drive(0, tv[c], 32'h20, 1'b1, 1'b1, tst[c]);
      #1;
      tests++;
      if (mem_addr_rdy[0] !== tr[c] || mem_data_vld[0] !== tdv[c]) begin
        failed++;
        $display("FAIL stall_handshake c%0d got rdy=%b dv=%b exp rdy=%b dv=%b", c, mem_addr_rdy[0], mem_data_vld[0], tr[c], tdv[c]);
      end
      if (tv[c] && tr[c]) sb_push(0, 32'h20, 1'b1, 2);
      if (mem_data_vld[0] === 1'b1) begin
        tests++;
        if (sb[0].size() == 0) begin
          failed++;
          $display("FAIL stall_beat c%0d got unexpected data %h exp no beat", c, mem_data[0]);
        end else begin
          e = sb[0].pop_front();
          if (mem_data[0] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL stall_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[0], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[0].size() != 0) begin
      failed++;
      $display("FAIL stall_drain got %0d beats outstanding exp 0", sb[0].size());
      sb[0].delete();
    end
  endtask

  task automatic test_gnt_low();
    exp_t e;
    logic [4:0] tv = 5'b01111, tg = 5'b11001, tr = 5'b11001, tdv = 5'b10010;
    logic [31:0] a;
    for (int c = 0; c < 5; c++) begin
      a = (c == 0) ? 32'h34 : 32'h38;
      drive(0, tv[c], a, 1'b1, tg[c], 1'b0);
      #1;
      tests++;
      if (mem_addr_rdy[0] !== tr[c] || sram_ce[0] !== (tv[c] & tr[c])) begin
        failed++;
        $display("FAIL gnt_handshake c%0d got rdy=%b ce=%b exp rdy=%b ce=%b", c, mem_addr_rdy[0], sram_ce[0], tr[c], tv[c] & tr[c]);
      end
      tests++;
      if (mem_data_vld[0] !== tdv[c]) begin
        failed++;
        $display("FAIL gnt_data_vld c%0d got %b exp %b", c, mem_data_vld[0], tdv[c]);
      end
      if (tv[c] && tr[c]) sb_push(0, a, 1'b1, 0);
      if (mem_data_vld[0] === 1'b1) begin
        tests++;
        if (sb[0].size() == 0) begin
          failed++;
          $display("FAIL gnt_beat c%0d got unexpected data %h exp no beat", c, mem_data[0]);
        end else begin
          e = sb[0].pop_front();
          if (mem_data[0] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL gnt_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[0], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests++;
    if (sb[0].size() != 0) begin
      failed++;
      $display("FAIL gnt_drain got %0d beats outstanding exp 0", sb[0].size());
      sb[0].delete();
    end
  endtask

  task automatic test_reset_mid_phase();
    exp_t e;
    logic [11:0] tv = 12'h081, tr = 12'h8FF, tdv = 12'h800;
    logic [31:0] a;
    for (int c = 0; c < 12; c++) begin
      a = (c == 0) ? 32'h40 : 32'h44;
      rst_n[2] = (c != 1);
      drive(2, tv[c], a, 1'b1, 1'b1, 1'b0);
      #1;
      tests++;
      if (mem_addr_rdy[2] !== tr[c] || sram_ce[2] !== (tv[c] & tr[c])) begin
        failed++;
        $display("FAIL rst_mid_handshake c%0d got rdy=%b ce=%b exp rdy=%b ce=%b", c, mem_addr_rdy[2], sram_ce[2], tr[c], tv[c] & tr[c]);
      end
      tests++;
      if (mem_data_vld[2] !== tdv[c]) begin
        failed++;
        $display("FAIL rst_mid_data_vld c%0d got %b exp %b", c, mem_data_vld[2], tdv[c]);
      end
      // The access accepted just before reset must never produce a beat.
      if (tv[c] && tr[c] && c != 0) sb_push(2, a, 1'b1, 0);
      if (mem_data_vld[2] === 1'b1) begin
        tests++;
        if (sb[2].size() == 0) begin
          failed++;
          $display("FAIL rst_mid_beat c%0d got unexpected data %h exp no beat", c, mem_data[2]);
        end else begin
          e = sb[2].pop_front();
          if (mem_data[2] !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL rst_mid_beat c%0d got %h at cycle %0d exp %h at cycle %0d", c, mem_data[2], cyc, e.data, e.due);
          end
        end
      end
      @(posedge clk); #1;
    end
    rst_n[2] = 1'b1;
    tests++;
    if (sb[2].size() != 0) begin
      failed++;
      $display("FAIL rst_mid_drain got %0d beats outstanding exp 0", sb[2].size());
      sb[2].delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + 32'(i);
    for (int k = 0; k < NI; k++) begin
      rst_n[k] = 1'b0;
      drive(k, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    @(posedge clk); @(posedge clk); #1;

    test_reset();
    test_back_to_back();
    test_halfword();
    test_wrap();
    test_wait_states();
    test_stall();
    test_gnt_low();
    test_reset_mid_phase();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
